chacha_block_feeder: RTL

Upstream stage for chacha20_poly1305_core. Accepts a 32-bit word stream with valid/ready handshake and packs it into 512-bit blocks with zero padding. Sequences the core's init/next/done/ready/valid/tag_ok handshake once per message. Tracks message byte length and flags a core-response timeout.

---
 rtl/chacha_pkg.sv | 36 +++
 rtl/chacha_word_packer.sv | 58 +++++
 rtl/chacha_block_feeder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared types and helpers for the ChaCha block feeder: FSM states, block
// geometry, and the byte-count / tail-byte mask helpers.
package chacha_pkg;

    localparam int BLOCK_W         = 512;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        INIT,
        NEXT,
        WAIT_VALID,
        DONE,
        WAIT_TAG
    } state_e;

    // 0 and anything above 4 count as a full word.
    function automatic logic [2:0] eff_bytes(input logic [2:0] nb);
        return ((nb == 3'd0) || (nb > 3'd4)) ? 3'd4 : nb;
    endfunction

    function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nb);
        case (eff_bytes(nb))
            3'd1:    return 32'h0000_00ff;
            3'd2:    return 32'h0000_ffff;
            3'd3:    return 32'h00ff_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/chacha_word_packer.sv
// Packs 32-bit words into a 512-bit block: lane index, lane write,
// tail-byte masking on the last word and whole-block clear.
module chacha_word_packer
    import chacha_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr,
    input  logic               first,
    input  logic               clr,
    input  logic [WORD_W-1:0]  data,
    input  logic               last,
    input  logic [2:0]         nbytes,
    output logic               full,
    output logic [BLOCK_W-1:0] block
);

    logic [IDX_W-1:0]   idx_q, idx_d, lane;
    logic [BLOCK_W-1:0] block_q, block_d;

    // The first word of a message always lands in lane 0 of a fresh block.
    assign lane  = first ? '0 : idx_q;
    assign full  = wr && (lane == LAST_LANE);
    assign block = block_q;

    always_comb begin
        block_d = block_q;
        idx_d   = idx_q;
        if (clr) begin
            block_d = '0;
            idx_d   = '0;
        end else if (wr) begin
            if (first) begin
                block_d = '0;
            end
            block_d[int'(lane)*WORD_W +: WORD_W] = last ? (data & byte_mask(nbytes)) : data;
            if (last) begin
                for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                    if (i > int'(lane)) begin
                        block_d[i*WORD_W +: WORD_W] = '0;
                    end
                end
            end
            idx_d = lane + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block_q <= '0;
            idx_q   <= '0;
        end else begin
            block_q <= block_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/chacha_block_feeder.sv
// Feeds a word stream into chacha20_poly1305_core as 512-bit blocks and
// sequences init/next/done per message, with a core-response timeout.
module chacha_block_feeder
    import chacha_pkg::*;
#(
    parameter int LEN_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_last,
    input  logic [2:0]         s_bytes,
    output logic               core_init,
    output logic               core_next,
    output logic               core_done,
    output logic [BLOCK_W-1:0] core_data_in,
    input  logic               core_ready,
    input  logic               core_valid,
    input  logic               core_tag_ok,
    output logic [LEN_W-1:0]   msg_len,
    output logic [LEN_W-1:0]   blk_cnt,
    output logic               busy,
    output logic               err
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic               s_ready_q, s_ready_d;
    logic               init_q, init_d, next_q, next_d, done_q, done_d;
    logic               err_q, err_d, last_q, last_d;
    logic [LEN_W-1:0]   msg_len_q, msg_len_d, blk_cnt_q, blk_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               accept, first_wr, blk_full, pk_clr, waiting, timeout;

    assign accept   = s_valid && s_ready_q;
    assign first_wr = accept && (state_q == IDLE);
    assign pk_clr   = (state_q == WAIT_VALID) && core_valid && !last_q;
    assign waiting  = (state_q == INIT) || (state_q == NEXT) ||
                      (state_q == WAIT_VALID) || (state_q == WAIT_TAG);

    chacha_word_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (accept),
        .first   (first_wr),
        .clr     (pk_clr),
        .data    (s_data),
        .last    (s_last),
        .nbytes  (s_bytes),
        .full    (blk_full),
        .block   (core_data_in)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            init_q    <= 1'b0;
            next_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= 1'b0;
            msg_len_q <= '0;
            blk_cnt_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            init_q    <= init_d;
            next_q    <= next_d;
            done_q    <= done_d;
            err_q     <= err_d;
            last_q    <= last_d;
            msg_len_q <= msg_len_d;
            blk_cnt_q <= blk_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            IDLE:       if (accept) state_d = s_last ? INIT : FILL;
            FILL:       if (accept && (s_last || blk_full))
                            state_d = (blk_cnt_q == '0) ? INIT : NEXT;
            INIT:       if (core_ready) state_d = NEXT;
            // Skip the cycle init is still high: the core has not yet had a
            // chance to drop ready, so a next pulse there would be lost.
            NEXT:       if (core_ready && !init_q) state_d = WAIT_VALID;
            WAIT_VALID: if (core_valid) state_d = last_q ? DONE : FILL;
            DONE:       state_d = WAIT_TAG;
            WAIT_TAG:   if (core_tag_ok) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (waiting && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
            timeout = 1'b1;
            state_d = IDLE;
        end
    end

    always_comb begin
        s_ready_d = (state_d == IDLE) || (state_d == FILL);
        init_d    = (state_q == INIT) && (state_d == NEXT);
        next_d    = (state_q == NEXT) && (state_d == WAIT_VALID);
        done_d    = (state_d == DONE);

        msg_len_d = msg_len_q;
        if (accept) begin
            msg_len_d = (first_wr ? '0 : msg_len_q) +
                        (s_last ? LEN_W'(eff_bytes(s_bytes)) : LEN_W'(4));
        end

        blk_cnt_d = blk_cnt_q;
        if (first_wr)    blk_cnt_d = '0;
        else if (next_d) blk_cnt_d = blk_cnt_q + 1'b1;

        err_d = err_q;
        if (first_wr)     err_d = 1'b0;
        else if (timeout) err_d = 1'b1;

        last_d = accept ? s_last : last_q;

        tmo_d = tmo_q;
        if (state_d != state_q) tmo_d = '0;
        else if (waiting)       tmo_d = tmo_q + 1'b1;
    end

    assign s_ready   = s_ready_q;
    assign core_init = init_q;
    assign core_next = next_q;
    assign core_done = done_q;
    assign msg_len   = msg_len_q;
    assign blk_cnt   = blk_cnt_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule
